// File: rtl/lcd_cmd_sched_if.sv
// rtl/lcd_cmd_sched_if.sv - host command and LCD controller handshake bundle
interface lcd_cmd_sched_if;
   logic [2:0] host_cmd;
   logic       host_valid;
   logic       host_ready;
   logic [2:0] lcd_cmd;
   logic       lcd_cmd_valid;
   logic       lcd_busy;
   logic       lcd_done;

   // Scheduler side: accepts host commands, drives the controller command port
   modport slave (
      input  host_cmd,
      input  host_valid,
      output host_ready,
      output lcd_cmd,
      output lcd_cmd_valid,
      input  lcd_busy,
      input  lcd_done
   );

   // Environment side: host source plus LCD controller
   modport master (
      output host_cmd,
      output host_valid,
      input  host_ready,
      input  lcd_cmd,
      input  lcd_cmd_valid,
      output lcd_busy,
      output lcd_done
   );
endinterface

// File: rtl/lcd_cmd_sched.sv
// rtl/lcd_cmd_sched.sv - buffers host commands and issues them to the LCD controller one at a time
module lcd_cmd_sched #(
   parameter int DEPTH = 8,
   parameter int CW    = 4
) (
   input  logic          clk,
   input  logic          reset,
   lcd_cmd_sched_if.slave bus,
   output logic [CW-1:0] fifo_count,
   output logic [7:0]    issued_cnt,
   output logic          sched_done
);
   localparam int AW = $clog2(DEPTH);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      ISSUE     = 3'd1,
      GUARD     = 3'd2,
      WAIT      = 3'd3,
      WAIT_DONE = 3'd4,
      FIN       = 3'd5
   } state_t;

   state_t        state;
   state_t        state_nx;
   logic [2:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic          wr_seen;
   logic          full;
   logic          empty;
   logic          push;
   logic          pop;

   assign full  = (count == CW'(DEPTH));
   assign empty = (count == '0);

   // Once a WRITE is queued the script is complete, so the host is shut out
   assign bus.host_ready    = !full && !wr_seen && (state != FIN);
   assign push              = bus.host_valid && bus.host_ready;
   assign pop               = (state == IDLE) && !empty && !bus.lcd_busy;
   assign bus.lcd_cmd_valid = (state == ISSUE);
   assign sched_done        = (state == FIN);
   assign fifo_count        = count;

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nx;
   end

   // Next-state decode; GUARD deliberately ignores busy for the cycle before the controller raises it
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:      if (pop) state_nx = ISSUE;
         ISSUE:     state_nx = (bus.lcd_cmd == 3'd0) ? WAIT_DONE : GUARD;
         GUARD:     state_nx = WAIT;
         WAIT:      if (!bus.lcd_busy) state_nx = IDLE;
         WAIT_DONE: if (bus.lcd_done) state_nx = FIN;
         FIN:       state_nx = FIN;
         default:   state_nx = IDLE;
      endcase
   end

   // Command storage; contents need no reset since count gates every read
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= bus.host_cmd;
   end

   // FIFO pointers, occupancy and the WRITE-seen flag
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         wr_seen <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
         if (push && (bus.host_cmd == 3'd0)) wr_seen <= 1'b1;
      end
   end

   // Head-of-queue command register; holds its value outside ISSUE
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)   bus.lcd_cmd <= 3'd0;
      else if (pop) bus.lcd_cmd <= mem[rd_ptr];
   end

   // Count of issue strobes, free-running modulo 256
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)              issued_cnt <= 8'd0;
      else if (state == ISSUE) issued_cnt <= issued_cnt + 8'd1;
   end
endmodule

// File: doc/lcd_cmd_sched.md
# lcd_cmd_sched

Command scheduler that sits between a host command source and the LCD controller's `cmd`/`cmd_valid`/`busy`/`done` port. Host commands are buffered in a small FIFO and issued one at a time, only when the controller reports not busy. Each command's busy window is tracked, and the controller's final WRITE/done sequence terminates the run. The host can stream a whole image-processing script without observing controller timing.

## Interface
- `DEPTH`, 8: FIFO depth in commands; must be a power of two, at least 2.
- `CW`, 4: count width, equal to log2(DEPTH)+1.

- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset.
- `host_cmd`  in  3  command code: 0 WRITE, 1 UP, 2 DOWN, 3 LEFT, 4 RIGHT, 5 AVERAGE, 6 MIRROR_X, 7 MIRROR_Y.
- `host_valid`  in  1  host offers `host_cmd`.
- `host_ready`  out  1  a push happens when `host_valid` and `host_ready` are both high.
- `lcd_cmd`  out  3  command to the controller.
- `lcd_cmd_valid`  out  1  one-cycle issue strobe.
- `lcd_busy`  in  1  controller busy.
- `lcd_done`  in  1  controller image write-back finished.
- `fifo_count`  out  CW  number of queued commands.
- `issued_cnt`  out  8  commands issued since reset; wraps from 255 to 0.
- `sched_done`  out  1  run complete; sticky until reset.

## Operation
- FIFO: circular buffer with read and write pointers of log2(DEPTH) bits each, plus a count.
  - `host_ready` = !full && !wr_seen && state != FIN.
  - `wr_seen` sets on the cycle a WRITE (0) is pushed. No further pushes are accepted after that.
  - A push and a pop in the same cycle leave the count unchanged. Both pointers wrap modulo DEPTH.
- State machine:
  - IDLE:
    - If the FIFO is not empty and `lcd_busy`=0: pop the head into the `lcd_cmd` register and go to ISSUE.
    - Otherwise stay in IDLE.
    - Controller preload (busy high after reset) is absorbed here.
  - ISSUE: `lcd_cmd_valid`=1 for exactly this cycle; increment `issued_cnt`.
    - If `lcd_cmd`==0, go to WAIT_DONE.
    - Otherwise go to GUARD.
  - GUARD: one cycle; `lcd_busy` is ignored. This covers the cycle before the controller raises busy. Then go to WAIT.
  - WAIT: stay while `lcd_busy`=1; go to IDLE when `lcd_busy`=0.
  - WAIT_DONE: stay until `lcd_done`=1, then go to FIN.
  - FIN: terminal; `sched_done`=1 and `host_ready`=0. Any FIFO contents remain; they are never popped.
- `lcd_cmd` holds its value outside ISSUE. The controller samples it only when `lcd_cmd_valid`=1.
- Commands reach the controller in FIFO order. No command is dropped or reordered.

## Timing
- Reset values (async assert, any cycle including mid-command):
  - state = IDLE
  - `lcd_cmd`=0, `lcd_cmd_valid`=0
  - `fifo_count`=0, both pointers 0
  - `issued_cnt`=0, `wr_seen`=0, `sched_done`=0
  - `host_ready`=1
- Release of reset is synchronous to `clk`. The first push is possible on the first rising edge after release.
- Push to `lcd_cmd_valid`, with an idle controller and an empty FIFO: pushed at edge t, popped at t+1, `lcd_cmd_valid` high from t+1 to t+2.
- Minimum issue spacing is 4 cycles: ISSUE, GUARD, WAIT (at least 1), IDLE.
- `lcd_cmd_valid` is never high while the registered state is anything other than ISSUE. It is never asserted in two consecutive cycles.
- All outputs are registered, or decoded from registered state, FIFO count and flags. There is no combinational path from `lcd_busy` to `lcd_cmd_valid`.
- Full FIFO: `host_ready`=0 in the same cycle the count reaches DEPTH. It rises in the cycle after a pop.
- A push of WRITE drops `host_ready` in the following cycle, even if the FIFO still has room.

## Test plan
- Reset, then hold `lcd_busy`=1 for 70 cycles while pushing RIGHT (4):
  - `fifo_count`=1, `lcd_cmd_valid`=0 throughout.
  - After busy falls, exactly one strobe with `lcd_cmd`=4; `issued_cnt`=1.
- Push 8 commands back-to-back (1,2,3,4,5,6,7,1) with busy held high:
  - `host_ready`=0 when `fifo_count`=8; a 9th push is refused.
  - After busy is released, issue order is exactly 1,2,3,4,5,6,7,1.
- Controller model holds busy for 1 cycle after each accepted command:
  - Issued strobes are 4 cycles apart.
  - `issued_cnt` increments by 1 per strobe.
- Push 5 then 0 (WRITE):
  - `host_ready` drops after the WRITE push.
  - `lcd_done` asserted 66 cycles after the WRITE strobe produces `sched_done`=1 one cycle later.
  - A later `host_valid` is ignored.
- Simultaneous push and pop with `fifo_count`=3: the count stays at 3 and the pointers wrap correctly across index 7 to 0.
- Assert `reset` low during WAIT with 4 commands queued: all outputs return to their reset values immediately, and no strobe occurs until a new push.
